des_key_sched_ctrl: RTL and testbench

Sequences DES key-schedule generation for the round datapath. On `start` it captures a 64-bit key, applies PC-1 to form C/D (28 bits each), then issues 16 round subkeys (PC-2 of C/D) one per valid/ready handshake. In decrypt mode it issues them in reverse order (K16..K1). It sits between the key input register and the Feistel round engine.

---
 rtl/des_key_sched_ctrl.sv | 137 +++++++++++++
 tb/tb_des_key_sched_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule sequencer: PC-1 on start, then 16 PC-2 subkeys over valid/ready, forward or reversed.
// Define KEY_PARITY_CHECK_EN to reject starts whose key bytes fail odd parity (sticky key_parity_err).
module des_key_sched_ctrl #(
  parameter int unsigned NROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:64] key,
  input  logic        decrypt,
  input  logic        abort,
  input  logic        subkey_ready,
  output logic [1:48] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done,
  output logic        key_parity_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:56] r_cd, w_cd_nxt, w_pc1, w_cd_rot;
  logic [3:0]  r_round, w_round_nxt;
  logic        r_dec, w_dec_nxt;
  logic        w_accept, w_hs, w_shift2;
  logic [4:0]  w_sidx;

  function automatic logic [1:28] rotl(input logic [1:28] h, input logic two);
    return two ? {h[3:28], h[1:2]} : {h[2:28], h[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] h, input logic two);
    return two ? {h[27:28], h[1:26]} : {h[28], h[1:27]};
  endfunction

  assign w_pc1 = {key[57], key[49], key[41], key[33], key[25], key[17], key[9],  key[1],
                  key[58], key[50], key[42], key[34], key[26], key[18], key[10], key[2],
                  key[59], key[51], key[43], key[35], key[27], key[19], key[11], key[3],
                  key[60], key[52], key[44], key[36],
                  key[63], key[55], key[47], key[39], key[31], key[23], key[15], key[7],
                  key[62], key[54], key[46], key[38], key[30], key[22], key[14], key[6],
                  key[61], key[53], key[45], key[37], key[29], key[21], key[13], key[5],
                  key[28], key[20], key[12], key[4]};

  assign subkey = {r_cd[14], r_cd[17], r_cd[11], r_cd[24], r_cd[1],  r_cd[5],
                   r_cd[3],  r_cd[28], r_cd[15], r_cd[6],  r_cd[21], r_cd[10],
                   r_cd[23], r_cd[19], r_cd[12], r_cd[4],  r_cd[26], r_cd[8],
                   r_cd[16], r_cd[7],  r_cd[27], r_cd[20], r_cd[13], r_cd[2],
                   r_cd[41], r_cd[52], r_cd[31], r_cd[37], r_cd[47], r_cd[55],
                   r_cd[30], r_cd[40], r_cd[51], r_cd[45], r_cd[33], r_cd[48],
                   r_cd[44], r_cd[49], r_cd[39], r_cd[56], r_cd[34], r_cd[53],
                   r_cd[46], r_cd[42], r_cd[50], r_cd[36], r_cd[29], r_cd[32]};

  // Shift-table index of the key issued next: encrypt walks rounds 2..16, decrypt undoes round 16-round.
  assign w_sidx   = r_dec ? (5'd16 - {1'b0, r_round}) : ({1'b0, r_round} + 5'd2);
  assign w_shift2 = !(w_sidx == 5'd1 || w_sidx == 5'd2 || w_sidx == 5'd9 || w_sidx == 5'd16);
  assign w_cd_rot = r_dec ? {rotr(r_cd[1:28], w_shift2), rotr(r_cd[29:56], w_shift2)}
                          : {rotl(r_cd[1:28], w_shift2), rotl(r_cd[29:56], w_shift2)};

`ifdef KEY_PARITY_CHECK_EN
  logic w_par_ok;
  logic r_perr;

  assign w_par_ok = (^key[1:8])   & (^key[9:16])  & (^key[17:24]) & (^key[25:32]) &
                    (^key[33:40]) & (^key[41:48]) & (^key[49:56]) & (^key[57:64]);
  assign w_accept = start & w_par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_perr <= 1'b0;
    else if (r_state == S_IDLE && start) r_perr <= !w_par_ok;
  end

  assign key_parity_err = r_perr;
`else
  logic w_unused_key_bits;

  assign w_unused_key_bits = ^{key[8], key[16], key[24], key[32], key[40], key[48], key[56], key[64]};
  assign w_accept          = start;
  assign key_parity_err    = 1'b0;
`endif

  assign subkey_valid = (r_state == S_RUN);
  assign busy         = (r_state == S_RUN);
  assign done         = (r_state == S_DONE);
  assign round        = r_round;
  assign w_hs         = subkey_valid & subkey_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cd    <= '0;
      r_round <= '0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cd    <= w_cd_nxt;
      r_round <= w_round_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_round_nxt = r_round;
    w_dec_nxt   = r_dec;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RUN;
          w_round_nxt = '0;
          w_dec_nxt   = decrypt;
          // Decrypt starts at C16/D16, which equals PC-1 output since the shifts total 28.
          w_cd_nxt    = decrypt ? w_pc1 : {rotl(w_pc1[1:28], 1'b0), rotl(w_pc1[29:56], 1'b0)};
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = '0;
        end else if (w_hs) begin
          if (r_round == 4'(NROUNDS - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_round_nxt = r_round + 4'd1;
            w_cd_nxt    = w_cd_rot;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Scoreboard bench for des_key_sched_ctrl using the classic 0x133457799BBCDFF1 subkey set.
// Define KEY_PARITY_CHECK_EN to also exercise the parity rejection path.
module tb_des_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:64] key = '0;
  logic        decrypt = 1'b0;
  logic        abort = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [1:48] subkey;
  logic        subkey_valid;
  logic [3:0]  round;
  logic        busy;
  logic        done;
  logic        key_parity_err;

  des_key_sched_ctrl #(.NROUNDS(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .key            (key),
    .decrypt        (decrypt),
    .abort          (abort),
    .subkey_ready   (subkey_ready),
    .subkey         (subkey),
    .subkey_valid   (subkey_valid),
    .round          (round),
    .busy           (busy),
    .done           (done),
    .key_parity_err (key_parity_err)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;

  logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  rnd;
    bit          last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rdy_rand = 1'b0;
  bit   exp_done_next = 1'b0;
  bit   hold_pend = 1'b0;
  logic [47:0] hold_sk;
  logic [3:0]  hold_rnd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    subkey_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every accepted handshake, checks hold stability and the done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_done_next = 1'b0;
      hold_pend     = 1'b0;
    end else begin
      if (exp_done_next) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("valid_after_last", 64'(subkey_valid), 64'd0);
        exp_done_next = 1'b0;
      end else if (done) begin
        chk("spurious_done", 64'(done), 64'd0);
      end
      if (hold_pend && subkey_valid) begin
        chk("hold_subkey", 64'(subkey), 64'(hold_sk));
        chk("hold_round", 64'(round), 64'(hold_rnd));
      end
      hold_pend = subkey_valid && !subkey_ready && !abort;
      hold_sk   = subkey;
      hold_rnd  = round;
      if (subkey_valid && subkey_ready && !abort) begin
        if (q.size() == 0) begin
          chk("extra_handshake_round", 64'(round), 64'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("subkey", 64'(subkey), 64'(e.sk));
          chk("round", 64'(round), 64'(e.rnd));
          if (e.last) exp_done_next = 1'b1;
        end
      end
    end
  end

  task automatic push_seq(input bit dec);
    for (int unsigned i = 0; i < 16; i++) begin
      exp_t e;
      e.sk   = dec ? KS[15 - i] : KS[i];
      e.rnd  = 4'(i);
      e.last = (i == 15);
      q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [63:0] k, input bit dec, input bit accept);
    @(posedge clk); #1;
    start   = 1'b1;
    key     = k;
    decrypt = dec;
    if (accept) push_seq(dec);
    @(negedge clk);
    chk("valid_before_accept", 64'(subkey_valid), 64'd0);
    @(posedge clk); #1;
    start   = 1'b0;
    decrypt = 1'b0;
    key     = '0;
    @(negedge clk);
    chk("valid_latency", 64'(subkey_valid), 64'(accept));
    chk("busy_after_start", 64'(busy), 64'(accept));
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while ((q.size() != 0 || subkey_valid || done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_timeout: %0d entries left, required 0", name, q.size());
    end
  endtask

  initial begin
    #12;
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_round", 64'(round), 64'd0);
    chk("rst_subkey", 64'(subkey), 64'd0);
    chk("rst_perr", 64'(key_parity_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_start(KEY_GOOD, 1'b0, 1'b1);
    wait_idle("encrypt");
    do_start(KEY_GOOD, 1'b1, 1'b1);
    wait_idle("decrypt");

    rdy_rand = 1'b1;
    do_start(KEY_GOOD, 1'b0, 1'b1);
    wait_idle("backpressure_enc");
    do_start(KEY_GOOD, 1'b1, 1'b1);
    wait_idle("backpressure_dec");
    rdy_rand = 1'b0;

    // Abort while round 5 is presented with ready high.
    do_start(KEY_GOOD, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_at_round", 64'(round), 64'd5);
    chk("abort_consumed", 64'(q.size()), 64'd11);
    @(posedge clk); #1;
    abort = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_valid", 64'(subkey_valid), 64'd0);
    chk("abort_round", 64'(round), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    repeat (4) @(negedge clk);
    do_start(KEY_GOOD, 1'b0, 1'b1);
    wait_idle("after_abort");

    // Start in RUN is ignored; then asynchronous reset at round 9.
    do_start(KEY_GOOD, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start   = 1'b1;
    key     = 64'h0123456789ABCDEF;
    decrypt = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    decrypt = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_consumed", 64'(q.size()), 64'd7);
    chk("reset_round_before", 64'(round), 64'd9);
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(subkey_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_round", 64'(round), 64'd0);
    chk("arst_subkey", 64'(subkey), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_start(KEY_GOOD, 1'b1, 1'b1);
    wait_idle("after_reset");

`ifdef KEY_PARITY_CHECK_EN
    do_start(64'h133457799BBCDFF0, 1'b0, 1'b0);
    chk("parity_err_set", 64'(key_parity_err), 64'd1);
    repeat (3) @(negedge clk);
    chk("parity_err_sticky", 64'(key_parity_err), 64'd1);
    chk("parity_busy", 64'(busy), 64'd0);
    do_start(KEY_GOOD, 1'b0, 1'b1);
    chk("parity_err_cleared", 64'(key_parity_err), 64'd0);
    wait_idle("after_parity");
`else
    chk("parity_err_off", 64'(key_parity_err), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
